wb_daq_dma_scheduler: RTL and testbench
=======================================

Name: wb_daq_dma_scheduler

Overview:
- Sequences the single DAQ Wishbone bus master among NUM_CH acquisition channels.
- Arbitrates channel SRAM-write requests round-robin and issues one start pulse per transfer.
- Generates the per-channel circular-buffer write address.
- Tracks completion, error and timeout, and raises wrap/error events toward the slave register block.

Parameters:
NUM_CH, 4, number of requesting channels
AW, 32, bus master address width
LEN_W, 16, width of per-channel buffer length (in 32-bit words)
TIMEOUT, 255, WAIT-state cycle limit before forced error; 0 disables timeout

Ports:
wb_clk  in  1  system clock; all logic on rising edge
wb_rst  in  1  asynchronous, active-low reset (0 = reset)
enable  in  NUM_CH  per-channel enable (from control registers)
request  in  NUM_CH  level request; channel holds it high until its done pulse
base_addr  in  NUM_CH*AW  per-channel buffer base; channel i at [i*AW +: AW]
buf_words  in  NUM_CH*LEN_W  per-channel buffer length in words; channel i at [i*LEN_W +: LEN_W]
clear  in  NUM_CH  one-cycle pulse; resets that channel's write offset to 0
master_done  in  1  bus master transfer-complete pulse (ack seen)
master_err  in  1  bus master error pulse (err/rty seen)
master_start  out  1  one-cycle start to bus master
master_address  out  AW  write address for the current transfer
select  out  clog2(NUM_CH)  index of the granted channel (data mux select)
grant  out  NUM_CH  one-hot; held from ISSUE through WAIT
active  out  1  high in ISSUE and WAIT
done  out  NUM_CH  one-cycle pulse to the served channel on success
wrap_irq  out  NUM_CH  one-cycle pulse when a channel's offset wraps to 0
err_irq  out  NUM_CH  one-cycle pulse on error or timeout for the granted channel
err_status  out  NUM_CH  sticky error flag; cleared by that channel's clear

Behaviour:
- Reset (wb_rst=0, async):
  - State=IDLE.
  - All outputs 0; all offsets 0.
  - Round-robin pointer = NUM_CH-1, so channel 0 has first priority.
  - Timeout counter = 0.
- Eligible[i] = request[i] & enable[i] & (buf_words[i] != 0).
- IDLE:
  - If any channel is eligible, pick the first eligible index searching upward from pointer+1 (mod NUM_CH).
  - Register select and grant, set pointer = winner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - master_start=1.
  - master_address = base_addr[sel] + (offset[sel] << 2), truncated mod 2^AW; held stable until IDLE.
  - Clear the timeout counter; go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - master_done: done[sel]=1 for one cycle.
    - If offset+1 >= buf_words[sel], offset=0 and wrap_irq[sel]=1; otherwise offset+1.
    - Go to IDLE.
  - master_err (priority over a simultaneous done): no offset change; err_irq[sel]=1; err_status[sel]=1; go to IDLE.
  - Timeout (TIMEOUT != 0 and counter reaches TIMEOUT-1 without done/err): same as error; go to IDLE.
- Start-to-start latency:
  - Request visible in IDLE at cycle N gives master_start at N+1.
  - The earliest next start is 2 cycles after done.
- clear[i]:
  - offset[i]=0 and err_status[i]=0.
  - Wins over a same-cycle update of channel i; no wrap_irq is generated.
  - A transfer in flight for channel i completes at its already-issued address.
- enable or request dropping during WAIT does not abort the transfer; it only affects the next arbitration.
- buf_words shrinking below the current offset: the next completion takes the >= test and wraps to 0.
- Single-channel fairness: the same channel may be re-granted back-to-back if it alone is eligible.

Test Plan:
1. Reset, then request=4'b0001, base0=0x1000, buf0=4, done 3 cycles after each start -> addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x1000. wrap_irq[0] pulses once, after the 4th done.
2. All four channels requesting continuously, all enabled -> grant order 0,1,2,3,0,1. master_start exactly 1 cycle wide each time. active low for exactly 1 cycle between transfers.
3. Channel 2 granted, master_err asserted together with master_done -> err_irq[2]=1 and err_status[2]=1, no done[2], offset2 unchanged. A following clear[2] drops err_status[2] to 0.
4. TIMEOUT=8, no done/err after start -> err_irq pulses 8 cycles into WAIT, state returns to IDLE, the next eligible channel is granted.
5. buf_words1=0 with request1 high, channel 0 also requesting -> only channel 0 is ever granted. enable3=0 masks channel 3 identically.
6. Assert wb_rst low mid-WAIT -> grant, active, master_start and all offsets go to 0 immediately. After release, channel 0 wins first and is issued at base0+0.

Source files
------------

// File: rtl/wb_daq_dma_scheduler.sv
// DAQ bus-master scheduler: round-robin arbitration among acquisition channels,
// circular-buffer write addressing, and completion / error / timeout tracking.
module wb_daq_dma_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int AW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       request,
  input  logic [NUM_CH*AW-1:0]    base_addr,
  input  logic [NUM_CH*LEN_W-1:0] buf_words,
  input  logic [NUM_CH-1:0]       clear,
  input  logic                    master_done,
  input  logic                    master_err,
  output logic                    master_start,
  output logic [AW-1:0]           master_address,
  output logic [SEL_W-1:0]        select,
  output logic [NUM_CH-1:0]       grant,
  output logic                    active,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       wrap_irq,
  output logic [NUM_CH-1:0]       err_irq,
  output logic [NUM_CH-1:0]       err_status
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [LEN_W-1:0] offset_r [NUM_CH];

  logic [NUM_CH-1:0] elig_s;
  logic [SEL_W-1:0]  win_s;
  logic              any_s;
  logic [LEN_W-1:0]  off_win_s;
  logic [AW-1:0]     issue_addr_s;
  logic [LEN_W-1:0]  bufw_sel_s;
  logic [LEN_W:0]    off_inc_s;
  logic              wrap_s;
  logic              tmo_hit_s;

  // Eligibility: requesting, enabled, and owning a non-empty buffer.
  always_comb begin
    elig_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      elig_s[i] = request[i] & enable[i] & (buf_words[i*LEN_W +: LEN_W] != {LEN_W{1'b0}});
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_s = ptr_r;
    any_s = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int   idx;
      logic hit;
      idx   = (int'(ptr_r) + k) % NUM_CH;
      hit   = ~any_s & elig_s[idx];
      win_s = hit ? SEL_W'(idx) : win_s;
      any_s = any_s | hit;
    end
  end

  // Issue address for the winner and completion arithmetic for the granted channel.
  always_comb begin
    // A clear arriving with the arbitration decision already counts for this transfer.
    off_win_s    = clear[win_s] ? {LEN_W{1'b0}} : offset_r[win_s];
    issue_addr_s = base_addr[int'(win_s)*AW +: AW] + AW'({off_win_s, 2'b00});
    bufw_sel_s   = buf_words[int'(select)*LEN_W +: LEN_W];
    off_inc_s    = {1'b0, offset_r[select]} + (LEN_W+1)'(1'b1);
    wrap_s       = (off_inc_s >= {1'b0, bufw_sel_s});
  end

  if (TIMEOUT == 0) begin : g_no_tmo
    assign tmo_hit_s = 1'b0;
  end else begin : g_tmo
    assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
  end

  // Scheduler FSM with registered outputs, per-channel offsets and sticky errors.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_r        <= ST_IDLE;
      ptr_r          <= SEL_W'(NUM_CH - 1);
      tmo_cnt_r      <= {TMO_W{1'b0}};
      master_start   <= 1'b0;
      master_address <= {AW{1'b0}};
      select         <= {SEL_W{1'b0}};
      grant          <= {NUM_CH{1'b0}};
      active         <= 1'b0;
      done           <= {NUM_CH{1'b0}};
      wrap_irq       <= {NUM_CH{1'b0}};
      err_irq        <= {NUM_CH{1'b0}};
      err_status     <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        offset_r[i] <= {LEN_W{1'b0}};
      end
    end else begin
      master_start <= 1'b0;
      done         <= {NUM_CH{1'b0}};
      wrap_irq     <= {NUM_CH{1'b0}};
      err_irq      <= {NUM_CH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r        <= ST_ISSUE;
            ptr_r          <= win_s;
            select         <= win_s;
            grant          <= NUM_CH'(1'b1) << win_s;
            active         <= 1'b1;
            master_start   <= 1'b1;
            master_address <= issue_addr_s;
          end
        end
        ST_ISSUE: begin
          tmo_cnt_r <= {TMO_W{1'b0}};
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
          // Error (bus or timeout) outranks a simultaneous completion.
          if (master_err || tmo_hit_s) begin
            err_irq[select]    <= 1'b1;
            err_status[select] <= 1'b1;
            grant              <= {NUM_CH{1'b0}};
            active             <= 1'b0;
            state_r            <= ST_IDLE;
          end else if (master_done) begin
            done[select] <= 1'b1;
            if (wrap_s) begin
              offset_r[select] <= {LEN_W{1'b0}};
              wrap_irq[select] <= 1'b1;
            end else begin
              offset_r[select] <= off_inc_s[LEN_W-1:0];
            end
            grant   <= {NUM_CH{1'b0}};
            active  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          grant   <= {NUM_CH{1'b0}};
          active  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
      // Software clear overrides any same-cycle offset or status update.
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear[i]) begin
          offset_r[i]   <= {LEN_W{1'b0}};
          err_status[i] <= 1'b0;
          wrap_irq[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_daq_dma_scheduler.sv
// Directed, table-driven bench for the DAQ scheduler (TIMEOUT=8 instance).
module tb_wb_daq_dma_scheduler;

  logic         wb_clk;
  logic         wb_rst;
  logic [3:0]   enable, request, clear;
  logic [127:0] base_addr;
  logic [63:0]  buf_words;
  logic         master_done, master_err;
  logic         master_start;
  logic [31:0]  master_address;
  logic [1:0]   select;
  logic [3:0]   grant, done, wrap_irq, err_irq, err_status;
  logic         active;

  int checks = 0;
  int errors = 0;

  wb_daq_dma_scheduler #(.NUM_CH(4), .AW(32), .LEN_W(16), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .request(request),
    .base_addr(base_addr), .buf_words(buf_words), .clear(clear),
    .master_done(master_done), .master_err(master_err),
    .master_start(master_start), .master_address(master_address),
    .select(select), .grant(grant), .active(active), .done(done),
    .wrap_irq(wrap_irq), .err_irq(err_irq), .err_status(err_status)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // kind: 0 = done, 1 = err together with done, 2 = no response (timeout)
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [15:0] b1;
    int          kind;
    int          delay;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [3:0]  wrap;
    logic [3:0]  errst;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] en, input logic [3:0] clr,
                              input logic [15:0] b1, input int kind, input int delay,
                              input logic [1:0] sel, input logic [31:0] addr,
                              input logic [3:0] wrap, input logic [3:0] errst);
    vec_t v;
    v.req = req; v.en = en; v.clr = clr; v.b1 = b1; v.kind = kind; v.delay = delay;
    v.sel = sel; v.addr = addr; v.wrap = wrap; v.errst = errst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (n < 20 && master_start !== 1'b1) begin
      @(negedge wb_clk);
      n++;
    end
    chk("start_seen", {31'd0, master_start}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    // Channel 0 alone, buffer of 4 words: wraps after the 4th completion.
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1000, 4'h0, 4'h0));
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1004, 4'h0, 4'h0));
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1008, 4'h0, 4'h0));
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h100C, 4'h1, 4'h0));
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1000, 4'h0, 4'h0));
    // All requesting: rotation continues after channel 0.
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 3, 2'd1, 32'h2000, 4'h0, 4'h0));
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 2, 2'd2, 32'h3000, 4'h0, 4'h0));
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 1, 2'd3, 32'h4000, 4'h0, 4'h0));
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1004, 4'h0, 4'h0));
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 3, 2'd1, 32'h2004, 4'h0, 4'h0));
    vq.push_back(mk(4'hF, 4'hF, 4'h0, 16'd4, 0, 3, 2'd2, 32'h3004, 4'h0, 4'h0));
    // Error beats done; offset 2 stays at 2, then clear rewinds it.
    vq.push_back(mk(4'h4, 4'hF, 4'h0, 16'd4, 1, 2, 2'd2, 32'h3008, 4'h0, 4'h4));
    vq.push_back(mk(4'h4, 4'hF, 4'h4, 16'd4, 0, 3, 2'd2, 32'h3000, 4'h0, 4'h0));
    // Timeout on channel 3, then channel 0 gets the bus.
    vq.push_back(mk(4'h9, 4'hF, 4'h0, 16'd4, 2, 0, 2'd3, 32'h4004, 4'h0, 4'h8));
    vq.push_back(mk(4'h9, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1008, 4'h0, 4'h8));
    vq.push_back(mk(4'h1, 4'hF, 4'h0, 16'd4, 0, 3, 2'd0, 32'h100C, 4'h1, 4'h8));
    // Zero-length buffer and disabled channel are never granted.
    vq.push_back(mk(4'h3, 4'hF, 4'h0, 16'd0, 0, 3, 2'd0, 32'h1000, 4'h0, 4'h8));
    vq.push_back(mk(4'h3, 4'hF, 4'h0, 16'd0, 0, 3, 2'd0, 32'h1004, 4'h0, 4'h8));
    vq.push_back(mk(4'h9, 4'h7, 4'h0, 16'd4, 0, 3, 2'd0, 32'h1008, 4'h0, 4'h8));
    vq.push_back(mk(4'h9, 4'h7, 4'h0, 16'd4, 0, 3, 2'd0, 32'h100C, 4'h1, 4'h8));
    // Buffer shrunk below the current offset forces a wrap.
    vq.push_back(mk(4'h2, 4'hF, 4'h0, 16'd2, 0, 3, 2'd1, 32'h2008, 4'h2, 4'h8));
    vq.push_back(mk(4'h2, 4'hF, 4'h0, 16'd2, 0, 3, 2'd1, 32'h2000, 4'h0, 4'h8));

    wb_rst = 1'b0; enable = 4'hF; request = 4'h0; clear = 4'h0;
    master_done = 1'b0; master_err = 1'b0;
    base_addr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    buf_words = {16'd4, 16'd4, 16'd4, 16'd4};
    repeat (3) @(negedge wb_clk);
    chk("rst_grant", grant, 4'h0);
    chk("rst_active", active, 1'b0);
    chk("rst_start", master_start, 1'b0);
    chk("rst_addr", master_address, 32'h0);
    chk("rst_select", select, 2'd0);
    chk("rst_errst", err_status, 4'h0);
    wb_rst = 1'b1;
    @(negedge wb_clk);

    foreach (vq[r]) begin
      v = vq[r];
      enable = v.en;
      buf_words[16 +: 16] = v.b1;
      if (v.clr != 4'h0) begin
        request = 4'h0;
        clear   = v.clr;
        @(negedge wb_clk);
        clear = 4'h0;
        chk("clr_errst", err_status & v.clr, 4'h0);
      end
      request = v.req;
      wait_start(n);
      chk("latency", n, 1);
      chk("select", select, v.sel);
      chk("grant", grant, 4'b0001 << v.sel);
      chk("active", active, 1'b1);
      chk("address", master_address, v.addr);
      @(negedge wb_clk);
      chk("start_width", master_start, 1'b0);
      if (v.kind == 2) begin
        repeat (8) @(negedge wb_clk);
      end else begin
        repeat (v.delay - 1) @(negedge wb_clk);
        master_done = 1'b1;
        master_err  = (v.kind == 1);
        @(negedge wb_clk);
        master_done = 1'b0;
        master_err  = 1'b0;
      end
      chk("done", done, (v.kind == 0) ? (4'b0001 << v.sel) : 4'h0);
      chk("err_irq", err_irq, (v.kind != 0) ? (4'b0001 << v.sel) : 4'h0);
      chk("wrap_irq", wrap_irq, v.wrap);
      chk("err_status", err_status, v.errst);
      chk("idle_active", active, 1'b0);
      chk("idle_grant", grant, 4'h0);
    end

    // Reset in the middle of a channel-1 transfer.
    request = 4'h2;
    wait_start(n);
    chk("pre_rst_select", select, 2'd1);
    chk("pre_rst_addr", master_address, 32'h2004);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 4'h0);
    chk("mid_rst_active", active, 1'b0);
    chk("mid_rst_start", master_start, 1'b0);
    chk("mid_rst_addr", master_address, 32'h0);
    chk("mid_rst_errst", err_status, 4'h0);
    @(negedge wb_clk);
    wb_rst  = 1'b1;
    request = 4'hF;
    wait_start(n);
    chk("post_rst_select", select, 2'd0);
    chk("post_rst_addr", master_address, 32'h1000);
    repeat (3) @(negedge wb_clk);
    master_done = 1'b1;
    @(negedge wb_clk);
    master_done = 1'b0;
    chk("post_rst_done", done, 4'h1);
    wait_start(n);
    chk("post_rst_select1", select, 2'd1);
    chk("post_rst_addr1", master_address, 32'h2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
